// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the 4-bit add/subtract sequencer.
package alu_seq_pkg;

    localparam int ALU_WIDTH = 4;

    // Implicit A operand used by INC/DEC so they reuse the add/subtract path.
    localparam logic [ALU_WIDTH-1:0] INC_OPERAND = 4'b0001;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_A = 3'd1,
        LOAD_B = 3'd2,
        EXEC   = 3'd3,
        WRITE  = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        ADD = 2'd0,
        SUB = 2'd1,
        INC = 2'd2,
        DEC = 2'd3
    } op_t;

    // SUB and DEC run the unit in B-A mode; ADD and INC in B+A mode.
    function automatic logic is_subtract(op_t op);
        return (op == SUB) || (op == DEC);
    endfunction

endpackage

// File: rtl/alu_sequencer.sv
// Multi-cycle controller for the 4-bit add/subtract unit: collects operands
// from the internal bus, lets the unit settle for a cycle, then captures the
// sum/carry into the result register and flags.
//
// Request handshake: Start is a single-cycle strobe sampled only in IDLE
// (Busy=0); the operation is accepted on that edge and Op is latched with it.
// Operand handshake: IbIn is consumed on a rising edge where IbValid=1 while
// in LOAD_A/LOAD_B; with IbValid=0 the FSM simply waits. Done pulses for one
// cycle when the result is written. Abort cancels LOAD_A/LOAD_B/EXEC only.
module alu_sequencer
    import alu_seq_pkg::*;
(
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 Start,
    input  logic [1:0]           Op,
    input  logic                 Abort,
    input  logic [ALU_WIDTH-1:0] IbIn,
    input  logic                 IbValid,
    input  logic [ALU_WIDTH-1:0] AluSum,
    input  logic                 AluCarry,
    output logic [ALU_WIDTH-1:0] AluA,
    output logic [ALU_WIDTH-1:0] AluB,
    output logic                 AddSub,
    output logic                 EnableAlu,
    output logic                 Busy,
    output logic                 Done,
    output logic [ALU_WIDTH-1:0] Result,
    output logic                 CarryFlag,
    output logic                 ZeroFlag,
    output logic [2:0]           DbgState
);

    state_t                 state_q, state_d;
    op_t                    op_q, op_d;
    logic [ALU_WIDTH-1:0]   a_q, a_d;
    logic [ALU_WIDTH-1:0]   b_q, b_d;
    logic [ALU_WIDTH-1:0]   result_q, result_d;
    logic                   carry_q, carry_d;
    logic                   zero_q, zero_d;

    // State, operand and result registers with synchronous reset.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q  <= IDLE;
            op_q     <= ADD;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            zero_q   <= zero_d;
        end
    end

    // Next-state and register-update logic; every register holds by default.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        carry_d  = carry_q;
        zero_d   = zero_q;

        case (state_q)
            IDLE: begin
                // Start wins over a simultaneous Abort here.
                if (Start) begin
                    op_d = op_t'(Op);
                    if ((op_t'(Op) == INC) || (op_t'(Op) == DEC)) begin
                        a_d     = INC_OPERAND;
                        state_d = LOAD_B;
                    end else begin
                        state_d = LOAD_A;
                    end
                end
            end
            LOAD_A: begin
                if (Abort) begin
                    state_d = IDLE;
                end else if (IbValid) begin
                    a_d     = IbIn;
                    state_d = LOAD_B;
                end
            end
            LOAD_B: begin
                if (Abort) begin
                    state_d = IDLE;
                end else if (IbValid) begin
                    b_d     = IbIn;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                // One full cycle for the unit to settle on stable operands.
                state_d = Abort ? IDLE : WRITE;
            end
            WRITE: begin
                // Abort is ignored: the write always completes.
                result_d = AluSum;
                carry_d  = AluCarry;
                zero_d   = (AluSum == '0);
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decoded from registers and state only.
    always_comb begin
        AluA      = a_q;
        AluB      = b_q;
        AddSub    = ((state_q == EXEC) || (state_q == WRITE)) && is_subtract(op_q);
        EnableAlu = (state_q == WRITE);
        Done      = (state_q == WRITE);
        Busy      = (state_q != IDLE);
        Result    = result_q;
        CarryFlag = carry_q;
        ZeroFlag  = zero_q;
        DbgState  = state_q;
    end

endmodule
